data_mem_load_ctrl: RTL

- Read-side engine for data memory: accepts a load command (base row, row count, bank mask) and streams `mem_word_t` rows from data memory toward the register banks.
- Issues row reads, absorbs the fixed `DATA_MEM_RD_LATENCY`, buffers returned rows in a small FIFO, and presents them on a valid/ready stream.
- Sits between the data-memory macro read port and the register-bank write path. It is the reader counterpart to the bank-to-memory store path.

---
 rtl/hw_config_pkg.sv | 28 ++
 rtl/mem_word_fifo.sv | 55 +++++
 rtl/data_mem_load_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hw_config_pkg.sv
// Shared data-memory configuration and load-path types.
// Contents: memory geometry constants, row/mask typedefs, load command and FSM state types.
// Consumers import this package; modules re-expose the geometry as overridable parameters.
package hw_config_pkg;

    localparam int N_BANKS             = 64;
    localparam int BIT_L               = 32;
    localparam int DATA_MEM_ADDR_L     = 11;
    localparam int DATA_MEM_RD_LATENCY = 1;
    localparam int LOAD_LEN_L          = DATA_MEM_ADDR_L + 1;

    typedef logic [BIT_L-1:0]         word_t;
    typedef logic [N_BANKS*BIT_L-1:0] mem_word_t;
    typedef logic [N_BANKS-1:0]       bank_mask_t;

    typedef struct packed {
        logic [DATA_MEM_ADDR_L-1:0] base;
        logic [LOAD_LEN_L-1:0]      len;
        bank_mask_t                 mask;
    } load_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/mem_word_fifo.sv
// Synchronous FIFO of memory rows (row data plus sideband bits packed into WIDTH).
// Ports: i_push/i_push_dat write, i_pop advances head, o_head_dat is the registered head entry, o_full/o_empty/o_count status.
// Head is read straight from storage (no fall-through); caller must not push when full or pop when empty.
module mem_word_fifo #(
    parameter int WIDTH = 2049,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_dat,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [WIDTH-1:0]           o_head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_push_dat;
                r_wptr        <= ptr_next(r_wptr);
            end
            if (i_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rptr];

endmodule

// File: rtl/data_mem_load_ctrl.sv
// Load engine: takes {base,len,mask}, reads len consecutive rows (wrapping) and streams them out on valid/ready.
// Latency: handshake T -> first read T+1 -> first out_vld T+2+RD_LAT; 1 row/cycle sustained with out_rdy high.
// Backpressure: reads are only issued while FIFO entries + reads in flight (less this cycle's pop) leave room.
module data_mem_load_ctrl
    import hw_config_pkg::*;
#(
    parameter int N_BANKS    = hw_config_pkg::N_BANKS,
    parameter int BIT_L      = hw_config_pkg::BIT_L,
    parameter int ADDR_L     = hw_config_pkg::DATA_MEM_ADDR_L,
    parameter int RD_LAT     = hw_config_pkg::DATA_MEM_RD_LATENCY,
    parameter int FIFO_DEPTH = RD_LAT + 1,
    parameter int LEN_L      = ADDR_L + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [ADDR_L-1:0]        cmd_base_addr,
    input  logic [LEN_L-1:0]         cmd_len,
    input  logic [N_BANKS-1:0]       cmd_bank_mask,
    output logic                     mem_rd_en,
    output logic [ADDR_L-1:0]        mem_rd_addr,
    input  logic [N_BANKS*BIT_L-1:0] mem_rd_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [N_BANKS*BIT_L-1:0] out_data,
    output logic [N_BANKS-1:0]       out_bank_mask,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam int DW = N_BANKS * BIT_L;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // wide enough for fifo count + every in-flight read without wrapping
    localparam int SW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    load_state_t r_state;
    load_state_t w_state_nxt;

    logic [ADDR_L-1:0]  r_base;
    logic [LEN_L-1:0]   r_len;
    logic [LEN_L-1:0]   r_issued;
    logic [N_BANKS-1:0] r_mask;
    logic [ADDR_L-1:0]  r_last_addr;
    logic [RD_LAT-1:0]  r_sr_vld;
    logic [RD_LAT-1:0]  r_sr_last;

    logic              w_cmd_fire;
    logic              w_pop;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_ret_vld;
    logic [ADDR_L-1:0] w_issue_addr;
    logic [SW-1:0]     w_inflight;
    logic [SW-1:0]     w_reserved;
    logic [CW-1:0]     w_fifo_cnt;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DW:0]       w_fifo_head;

    assign w_cmd_fire = cmd_vld && cmd_rdy;
    assign w_pop      = out_vld && out_rdy;
    assign w_ret_vld  = r_sr_vld[RD_LAT-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + SW'(r_sr_vld[i]);
        end
    end

    // a pop this cycle frees a slot in time for a read issued now
    assign w_reserved   = SW'(w_fifo_cnt) + w_inflight - SW'(w_pop);
    assign w_issue      = (r_state == RUN) && (r_issued < r_len) && (w_reserved < SW'(FIFO_DEPTH));
    assign w_issue_addr = r_base + r_issued[ADDR_L-1:0];
    assign w_issue_last = (r_issued == r_len - 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cmd_fire) w_state_nxt = (cmd_len != '0) ? RUN : DONE;
            RUN:     if (w_pop && out_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_mask      <= '0;
            r_last_addr <= '0;
            r_sr_vld    <= '0;
            r_sr_last   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_fire) begin
                r_base   <= cmd_base_addr;
                r_len    <= cmd_len;
                r_mask   <= cmd_bank_mask;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued    <= r_issued + 1'b1;
                r_last_addr <= w_issue_addr;
            end
            // read-tracking pipe: bit RD_LAT-1 marks the cycle mem_rd_data is valid
            r_sr_vld[0]  <= w_issue;
            r_sr_last[0] <= w_issue && w_issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_sr_vld[i]  <= r_sr_vld[i-1];
                r_sr_last[i] <= r_sr_last[i-1];
            end
        end
    end

    mem_word_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_ret_vld),
        .i_push_dat ({mem_rd_data, r_sr_last[RD_LAT-1]}),
        .i_pop      (w_pop),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_cnt),
        .o_head_dat (w_fifo_head)
    );

    // the credit rule guarantees a return never lands on a full FIFO unless a pop makes room
    always_ff @(posedge clk) begin
        if (rst && w_ret_vld && w_fifo_full) begin
            assert (w_pop);
        end
    end

    // cmd_rdy is gated so every output reads 0 while reset is held
    assign cmd_rdy       = (r_state == IDLE) && rst;
    assign busy          = (r_state == RUN);
    assign done          = (r_state == DONE);
    assign mem_rd_en     = w_issue;
    assign mem_rd_addr   = w_issue ? w_issue_addr : r_last_addr;
    assign out_vld       = !w_fifo_empty;
    assign out_data      = w_fifo_head[DW:1];
    assign out_last      = w_fifo_head[0];
    assign out_bank_mask = r_mask;

endmodule
